// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack sequencer: operation codes, address
// register file control codes, output-select constants and FSM states.
package stack_seq_pkg;

  // Operation codes presented on Op
  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  // Address register file function codes
  localparam logic [1:0] FUN_DEC   = 2'b00;
  localparam logic [1:0] FUN_INC   = 2'b01;
  localparam logic [1:0] FUN_LOAD  = 2'b10;
  localparam logic [1:0] FUN_CLEAR = 2'b11;

  // Address register file enable masks
  localparam logic [2:0] REGSEL_NONE = 3'b000;
  localparam logic [2:0] REGSEL_PC   = 3'b100;
  localparam logic [2:0] REGSEL_SP   = 3'b010;
  localparam logic [2:0] REGSEL_AR   = 3'b001;

  // Fixed output selects: OutC carries PC, OutD carries SP
  localparam logic [1:0] OUTC_SEL_PC = 2'b00;
  localparam logic [1:0] OUTD_SEL_SP = 2'b01;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DEC  = 3'd1,
    S_WH   = 3'd2,
    S_WL   = 3'd3,
    S_RL   = 3'd4,
    S_RH   = 3'd5,
    S_LDPC = 3'd6,
    S_DONE = 3'd7
  } state_t;

endpackage

// File: rtl/stack_sequencer.sv
// Stack sequencer: drives an external address register file and byte-wide
// memory to perform PUSH, POP, CALL and RET on a full-descending,
// little-endian 16-bit stack.
//
// Handshake: Req is sampled only while Busy=0 (IDLE); a rising edge with
// Req=1 in IDLE accepts the request and latches Op, WData and PCValue.
// Busy stays high until the cycle after the one-cycle Done pulse, and any
// Req seen while Busy=1 (including the Done cycle) is ignored.
module stack_sequencer
  import stack_seq_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req,
  input  logic [1:0]  Op,
  input  logic [15:0] WData,
  input  logic [15:0] PCValue,
  input  logic [15:0] ARF_OutD,
  input  logic [7:0]  Mem_Q,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] RData,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [15:0] ARF_I,
  output logic [15:0] Mem_Address,
  output logic [7:0]  Mem_Data,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [2:0]  dbg_state
);

  state_t      state;
  state_t      state_next;
  logic [1:0]  op_q;
  logic [15:0] wdata_q;
  logic [15:0] pc_q;
  logic [15:0] rdata_q;
  logic [15:0] push_data;

  // CALL pushes the return address; PUSH pushes the caller's data
  assign push_data   = (op_q == OP_CALL) ? pc_q : wdata_q;

  assign Busy        = (state != S_IDLE);
  assign RData       = rdata_q;
  assign ARF_OutCSel = OUTC_SEL_PC;
  assign ARF_OutDSel = OUTD_SEL_SP;
  assign Mem_Address = ARF_OutD;
  assign dbg_state   = state;

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Request latches at accept and popped-byte capture during reads
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_q    <= OP_PUSH;
      wdata_q <= '0;
      pc_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (state == S_IDLE && Req) begin
        op_q    <= Op;
        wdata_q <= WData;
        pc_q    <= PCValue;
      end
      if (state == S_RL) rdata_q[7:0]  <= Mem_Q;
      if (state == S_RH) rdata_q[15:8] <= Mem_Q;
    end
  end

  // Next-state and per-state register-file / memory controls
  always_comb begin
    state_next = state;
    Done       = 1'b0;
    ARF_RegSel = REGSEL_NONE;
    ARF_FunSel = FUN_DEC;
    ARF_I      = '0;
    Mem_Data   = '0;
    Mem_WR     = 1'b0;
    Mem_CS     = 1'b0;
    case (state)
      S_IDLE: begin
        if (Req) state_next = (Op == OP_PUSH || Op == OP_CALL) ? S_DEC : S_RL;
      end
      S_DEC: begin
        // Pre-decrement so SP addresses the high byte's slot
        ARF_RegSel = REGSEL_SP;
        ARF_FunSel = FUN_DEC;
        state_next = S_WH;
      end
      S_WH: begin
        Mem_CS     = 1'b1;
        Mem_WR     = 1'b1;
        Mem_Data   = push_data[15:8];
        ARF_RegSel = REGSEL_SP;
        ARF_FunSel = FUN_DEC;
        state_next = S_WL;
      end
      S_WL: begin
        Mem_CS     = 1'b1;
        Mem_WR     = 1'b1;
        Mem_Data   = push_data[7:0];
        state_next = (op_q == OP_CALL) ? S_LDPC : S_DONE;
      end
      S_RL: begin
        Mem_CS     = 1'b1;
        ARF_RegSel = REGSEL_SP;
        ARF_FunSel = FUN_INC;
        state_next = S_RH;
      end
      S_RH: begin
        Mem_CS     = 1'b1;
        ARF_RegSel = REGSEL_SP;
        ARF_FunSel = FUN_INC;
        state_next = (op_q == OP_RET) ? S_LDPC : S_DONE;
      end
      S_LDPC: begin
        // RET jumps to the popped address, CALL to the latched target
        ARF_RegSel = REGSEL_PC;
        ARF_FunSel = FUN_LOAD;
        ARF_I      = (op_q == OP_RET) ? rdata_q : wdata_q;
        state_next = S_DONE;
      end
      S_DONE: begin
        Done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
